// File: rtl/packet_to_serial_pkg.sv
// Shared framing definitions for the host link: frame header byte, length
// field width and the transmit framer's state encoding.
package Framing;

  localparam logic [7:0] HEADER_BYTE = 8'h51;
  localparam int         LEN_BITS    = 16;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_HEADER,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA
  } state_t;

endpackage

// File: rtl/packet_to_serial_if.sv
// Byte-stream handshakes of the transmit framer: payload input from the
// packet producer and framed output towards the UART transmitter.
interface packet_to_serial_if;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/packet_to_serial_ram.sv
// Payload buffer: simple dual-port RAM, one write port and a registered
// read port with one cycle of latency; contents are not reset.
module packet_buffer_ram #(
  parameter int ADDR_BITS = 11
) (
  input  logic                 clock,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [7:0]           wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [7:0]           rd_data
);

  logic [7:0] mem [2**ADDR_BITS];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/packet_to_serial.sv
// Transmit framer: buffers one packet, then emits header, 16-bit big-endian
// length and the payload; packets longer than the buffer are split into frames.
module packet_to_serial
  import Framing::*;
#(
  parameter logic [7:0] HEADER    = HEADER_BYTE,
  parameter int         ADDR_BITS = 11
) (
  input  logic              clock,
  input  logic              clear,
  packet_to_serial_if.slave bus,
  output logic              busy
);

  localparam int                  DEPTH     = 2 ** ADDR_BITS;
  localparam logic [LEN_BITS-1:0] LAST_SLOT = LEN_BITS'(DEPTH - 1);

  state_t               state;
  state_t               state_next;
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [LEN_BITS-1:0]  count;
  logic [7:0]           hdr_data;
  logic [7:0]           ram_data;
  logic                 load_fire;
  logic                 handshake;
  logic                 last_beat;

  assign bus.in_ready  = (state == ST_LOAD) && !clear;
  assign bus.out_valid = (state != ST_LOAD);
  assign bus.out_data  = (state == ST_DATA) ? ram_data : hdr_data;
  assign busy          = (state != ST_LOAD) || (count != '0);

  assign load_fire = bus.in_valid && bus.in_ready;
  assign handshake = bus.out_valid && bus.out_ready;
  assign last_beat = (LEN_BITS'(rd_ptr) == count - LEN_BITS'(1));

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= ST_LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Read address runs one step ahead on each handshake so the registered RAM
  // output already holds the next payload byte when DATA needs it.
  always_comb begin
    state_next = state;
    rd_addr    = rd_ptr;
    case (state)
      ST_LOAD: begin
        if (load_fire && (bus.in_last || count == LAST_SLOT)) begin
          state_next = ST_HEADER;
        end
      end
      ST_HEADER: begin
        if (handshake) state_next = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (handshake) state_next = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        rd_addr = '0;
        if (handshake) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (handshake) begin
          rd_addr = rd_ptr + ADDR_BITS'(1);
          if (last_beat) state_next = ST_LOAD;
        end
      end
      default: state_next = ST_LOAD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      hdr_data <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (load_fire) begin
            wr_ptr <= wr_ptr + ADDR_BITS'(1);
            count  <= count + LEN_BITS'(1);
          end
          if (state_next == ST_HEADER) hdr_data <= HEADER;
        end
        ST_HEADER: begin
          if (handshake) hdr_data <= count[LEN_BITS-1:8];
        end
        ST_LEN_HI: begin
          if (handshake) hdr_data <= count[7:0];
        end
        ST_DATA: begin
          if (handshake) begin
            if (last_beat) begin
              wr_ptr <= '0;
              rd_ptr <= '0;
              count  <= '0;
            end else begin
              rd_ptr <= rd_ptr + ADDR_BITS'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  packet_buffer_ram #(
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clock   (clock),
    .wr_en   (load_fire),
    .wr_addr (wr_ptr),
    .wr_data (bus.in_data),
    .rd_addr (rd_addr),
    .rd_data (ram_data)
  );

endmodule

// File: tb/tb_packet_to_serial.sv
// Bench for packet_to_serial: drives packets, collects framed output bytes
// and compares them with frames built from the packet list.
module tb_packet_to_serial;

  typedef logic [7:0] byte_q_t[$];

  localparam int         DEPTH      = 2048;
  localparam logic [7:0] EXP_HEADER = 8'h51;
  localparam int         TIMEOUT    = 10000;

  logic clock = 1'b0;
  logic clear;
  logic busy;

  packet_to_serial_if bus ();

  packet_to_serial dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_acc_cyc = 0;
  logic [7:0] got_q[$];
  int         got_cyc[$];
  logic [7:0] exp_q[$];
  int         ready_mode = 0;
  logic       toggle = 1'b1;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       mon_en = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // Output sink: chooses out_ready for the coming edge, records every byte
  // that will be handed over and checks that stalled bytes hold still.
  always @(negedge clock) begin
    logic rdy;
    if (mon_en) begin
      case (ready_mode)
        0: rdy = 1'b1;
        1: begin rdy = toggle; toggle = ~toggle; end
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (clear === 1'b1) begin
        prev_stall = 1'b0;
      end else if (prev_stall) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data) begin
          errors++;
          $display("[TB] FAIL stall_hold: out_valid=%b out_data=%h, required out_valid=1 out_data=%h",
                   bus.out_valid, bus.out_data, prev_data);
        end
      end
      bus.out_ready = rdy;
      if (bus.out_valid === 1'b1 && rdy) begin
        got_q.push_back(bus.out_data);
        got_cyc.push_back(cyc);
      end
      prev_stall = (clear !== 1'b1) && (bus.out_valid === 1'b1) && !rdy;
      prev_data  = bus.out_data;
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  // Reference framing: each packet is cut into chunks of at most DEPTH bytes,
  // every chunk becoming header, big-endian length, then its bytes.
  function automatic void append_expected(input byte_q_t pkt);
    int idx;
    int len;
    logic [15:0] l16;
    idx = 0;
    while (idx < pkt.size()) begin
      len = pkt.size() - idx;
      if (len > DEPTH) len = DEPTH;
      l16 = 16'(len);
      exp_q.push_back(EXP_HEADER);
      exp_q.push_back(l16[15:8]);
      exp_q.push_back(l16[7:0]);
      for (int j = 0; j < len; j++) exp_q.push_back(pkt[idx + j]);
      idx += len;
    end
  endfunction

  function automatic int first_diff();
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (got_q[i] !== exp_q[i]) return i;
    end
    if (got_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic byte_q_t random_packet(input int len);
    byte_q_t p;
    for (int i = 0; i < len; i++) p.push_back(8'($urandom));
    return p;
  endfunction

  task automatic start_test(input int mode);
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
    ready_mode = mode;
    toggle     = 1'b1;
  endtask

  task automatic send_packet(input byte_q_t pkt);
    int waited;
    for (int i = 0; i < pkt.size(); i++) begin
      tick();
      bus.in_valid = 1'b1;
      bus.in_data  = pkt[i];
      bus.in_last  = (i == pkt.size() - 1);
      waited = 0;
      while (bus.in_ready !== 1'b1) begin
        checks++;
        if (bus.out_valid !== 1'b1) begin
          errors++;
          $display("[TB] FAIL in_ready_load: in_ready=%b out_valid=%b, required in_ready=1 when not transmitting",
                   bus.in_ready, bus.out_valid);
        end
        if (waited++ > TIMEOUT) begin
          errors++;
          $display("[TB] FAIL in_ready_timeout: byte %0d never accepted, required acceptance within %0d cycles",
                   i, TIMEOUT);
          return;
        end
        tick();
      end
      last_acc_cyc = cyc;
    end
  endtask

  task automatic end_send();
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_out(input int n, input string name);
    int w;
    w = 0;
    while (got_q.size() < n && w < TIMEOUT) begin
      tick();
      w++;
    end
    checks++;
    if (got_q.size() < n) begin
      errors++;
      $display("[TB] FAIL %s_timeout: got %0d output bytes, required %0d", name, got_q.size(), n);
    end
  endtask

  task automatic test_reset();
    clear        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) tick();
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_in_ready: got %b, required 0", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_out_valid: got %b, required 0", bus.out_valid);
    end
    checks++;
    if (bus.out_data !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_out_data: got %h, required 00", bus.out_data);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_busy: got %b, required 0", busy);
    end
    clear = 1'b0;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset: in_ready=%b out_valid=%b, required in_ready=1 out_valid=0",
               bus.in_ready, bus.out_valid);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_single_byte();
    byte_q_t p;
    int d;
    start_test(0);
    p = {8'hA5};
    append_expected(p);
    send_packet(p);
    end_send();
    wait_out(4, "single");
    tick();
    checks++;
    if (got_q.size() < 4 || bus.in_ready !== 1'b1 || cyc != got_cyc[3] + 1) begin
      errors++;
      $display("[TB] FAIL single_in_ready: in_ready=%b at cycle %0d, required 1 on cycle after final handshake",
               bus.in_ready, cyc);
    end
    checks++;
    if (got_q.size() < 4 || got_cyc[0] != last_acc_cyc + 1 || got_cyc[3] != got_cyc[0] + 3) begin
      errors++;
      $display("[TB] FAIL single_timing: first byte cycle %0d last %0d, required %0d and %0d",
               (got_cyc.size() > 0) ? got_cyc[0] : -1, (got_cyc.size() > 3) ? got_cyc[3] : -1,
               last_acc_cyc + 1, last_acc_cyc + 4);
    end
    repeat (2) tick();
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("[TB] FAIL stream_single: byte %0d got %h required %h (%0d vs %0d bytes)", d,
               (d < got_q.size()) ? got_q[d] : 8'hxx, (d < exp_q.size()) ? exp_q[d] : 8'hxx,
               got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_stall();
    byte_q_t p;
    int d;
    start_test(1);
    p = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    append_expected(p);
    send_packet(p);
    end_send();
    wait_out(8, "stall");
    repeat (4) tick();
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("[TB] FAIL stream_stall: byte %0d got %h required %h (%0d vs %0d bytes)", d,
               (d < got_q.size()) ? got_q[d] : 8'hxx, (d < exp_q.size()) ? exp_q[d] : 8'hxx,
               got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_split();
    byte_q_t p;
    int d;
    start_test(0);
    p = random_packet(DEPTH + 2);
    append_expected(p);
    send_packet(p);
    end_send();
    wait_out(DEPTH + 2 + 6, "split");
    repeat (3) tick();
    checks++;
    if (got_q.size() < DEPTH + 6 || got_q[1] !== 8'h08 || got_q[2] !== 8'h00 ||
        got_q[DEPTH + 4] !== 8'h00 || got_q[DEPTH + 5] !== 8'h02) begin
      errors++;
      $display("[TB] FAIL split_lengths: frame lengths wrong or missing (%0d bytes), required 0800 then 0002",
               got_q.size());
    end
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("[TB] FAIL stream_split: byte %0d got %h required %h (%0d vs %0d bytes)", d,
               (d < got_q.size()) ? got_q[d] : 8'hxx, (d < exp_q.size()) ? exp_q[d] : 8'hxx,
               got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_valid_held();
    byte_q_t a;
    byte_q_t b;
    int d;
    start_test(0);
    a = random_packet(4);
    b = random_packet(3);
    append_expected(a);
    append_expected(b);
    send_packet(a);
    send_packet(b);
    end_send();
    wait_out(exp_q.size(), "valid_held");
    repeat (3) tick();
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("[TB] FAIL stream_valid_held: byte %0d got %h required %h (%0d vs %0d bytes)", d,
               (d < got_q.size()) ? got_q[d] : 8'hxx, (d < exp_q.size()) ? exp_q[d] : 8'hxx,
               got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_clear_mid_frame();
    byte_q_t p;
    int d;
    start_test(0);
    p = random_packet(10);
    send_packet(p);
    end_send();
    wait_out(5, "clear_pre");
    clear = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_mid_frame: out_valid=%b in_ready=%b busy=%b, required 0 0 0",
               bus.out_valid, bus.in_ready, busy);
    end
    clear = 1'b0;
    tick();
    got_q.delete();
    got_cyc.delete();
    repeat (5) tick();
    checks++;
    if (got_q.size() != 0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clear_abandon: %0d bytes emitted, in_ready=%b, required 0 bytes and in_ready=1",
               got_q.size(), bus.in_ready);
    end
    p = {8'h7E};
    append_expected(p);
    send_packet(p);
    end_send();
    wait_out(4, "clear_post");
    repeat (3) tick();
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("[TB] FAIL stream_after_clear: byte %0d got %h required %h (%0d vs %0d bytes)", d,
               (d < got_q.size()) ? got_q[d] : 8'hxx, (d < exp_q.size()) ? exp_q[d] : 8'hxx,
               got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    byte_q_t a;
    byte_q_t b;
    int d;
    start_test(0);
    a = random_packet(3);
    b = random_packet(1);
    append_expected(a);
    append_expected(b);
    send_packet(a);
    send_packet(b);
    end_send();
    wait_out(10, "back_to_back");
    repeat (3) tick();
    checks++;
    if (got_cyc.size() < 6 || got_cyc[5] != got_cyc[0] + 5) begin
      errors++;
      $display("[TB] FAIL b2b_throughput: first frame spanned %0d cycles, required 6",
               (got_cyc.size() > 5) ? got_cyc[5] - got_cyc[0] + 1 : -1);
    end
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("[TB] FAIL stream_back_to_back: byte %0d got %h required %h (%0d vs %0d bytes)", d,
               (d < got_q.size()) ? got_q[d] : 8'hxx, (d < exp_q.size()) ? exp_q[d] : 8'hxx,
               got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_random();
    byte_q_t p;
    int d;
    start_test(2);
    for (int k = 0; k < 6; k++) begin
      p = random_packet(int'($urandom_range(1, 24)));
      append_expected(p);
      send_packet(p);
    end
    end_send();
    wait_out(exp_q.size(), "random");
    repeat (4) tick();
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("[TB] FAIL stream_random: byte %0d got %h required %h (%0d vs %0d bytes)", d,
               (d < got_q.size()) ? got_q[d] : 8'hxx, (d < exp_q.size()) ? exp_q[d] : 8'hxx,
               got_q.size(), exp_q.size());
    end
  endtask

  initial begin
    clear = 1'b1;
    test_reset();
    test_single_byte();
    test_stall();
    test_split();
    test_valid_held();
    test_clear_mid_frame();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/packet_to_serial.md
# packet_to_serial

Framing encoder for the host link's transmit direction: accepts a byte packet (valid/data/last stream), buffers it, and emits a framed byte stream on the UART transmit path. The frame is a header byte, a 16-bit big-endian length, then the payload. It is the counterpart of `serial_to_packet` on the receive path, so the host-side decoder and our receiver share one frame format. It sits between a packet producer (the memory-to-packet DMA) and `Uart_tx_0`.

## Interface
Parameters:
- `HEADER` — default 8'h51 ('Q'); frame start byte, identical to the receiver's expected header.
- `ADDR_BITS` — default 11; payload buffer holds `DEPTH = 2**ADDR_BITS` bytes (2048).

Ports:
- `clock` — input, 1; sole clock.
- `clear` — input, 1; reset, synchronous and active-high.
- `in_valid` — input, 1; payload byte valid.
- `in_data` — input, 8; payload byte.
- `in_last` — input, 1; final byte of the packet.
- `in_ready` — output, 1; byte is accepted when `in_valid & in_ready`.
- `out_valid` — output, 1; framed byte valid (to `Uart_tx_0` `data_in_valid`).
- `out_data` — output, 8; framed byte.
- `out_ready` — input, 1; from `Uart_tx_0` `data_in_ready`.
- `busy` — output, 1; high in any state other than LOAD, or when LOAD has buffered at least one byte.

## Operation
- FSM states: LOAD, HEADER, LEN_HI, LEN_LO, DATA.
- LOAD:
  - `in_ready = 1`.
  - Each accepted byte is written to `buf[wr_ptr]`; `wr_ptr` and `count` (16-bit) increment.
  - Go to HEADER on an accepted byte with `in_last = 1`, or on the accepted byte that makes `count == DEPTH`.
  - The DEPTH case is a forced split. Remaining bytes of the producer's packet form the next frame, so no byte is dropped.
- HEADER: `out_data = HEADER`. On handshake, go to LEN_HI.
- LEN_HI: `out_data = count[15:8]`. On handshake, go to LEN_LO.
- LEN_LO: `out_data = count[7:0]`. On handshake, go to DATA.
  - The buffer read of address 0 is issued in this state, so the first payload byte is ready with no bubble.
- DATA:
  - `out_data = buf[rd_ptr]`.
  - On each handshake, `rd_ptr` increments and the next address is pre-read.
  - On the handshake with `rd_ptr == count-1`, reset `wr_ptr`, `rd_ptr` and `count` to 0 and return to LOAD.
- `in_ready = 0` in all states except LOAD; the producer back-pressures for the whole transmit phase.
- `count` is never 0 when leaving LOAD, because `last` always travels with a byte. With the defaults the length is at most 2048.
- `out_data` must hold stable while `out_valid & ~out_ready`.

## Timing
- While `clear` is high, on the next edge:
  - state = LOAD; `wr_ptr`, `rd_ptr`, `count` = 0.
  - `out_valid = 0`, `out_data = 0`, `busy = 0`.
  - `in_ready = 0` during the clear cycle, and 1 from the first cycle after `clear` falls.
- `clear` mid-frame abandons the frame. Buffered data is discarded and no further output bytes are produced.
- Latency: last payload byte accepted at edge t → `out_valid = 1` with HEADER on cycle t+1.
- Throughput: with `out_ready` held high, one framed byte per cycle. An N-byte packet takes exactly N+3 output cycles, and LOAD is re-entered the cycle after the final handshake.
- `out_valid` is low in LOAD and high in HEADER, LEN_HI, LEN_LO and DATA; it never drops without a handshake.
- Simultaneous events:
  - `in_valid` during a non-LOAD state is ignored (not accepted).
  - `out_ready` while in LOAD has no effect.

## Structure
- Shared package (`Framing`) holds:
  - the `HEADER` constant, shared with `serial_to_packet`;
  - the length field width (16);
  - the FSM state enum.
- Sub-module `packet_buffer_ram`: simple dual-port RAM, `DEPTH` x 8, one write port, registered read port with 1-cycle latency, no reset on contents.
- Registers: FSM state, pointers, `count`, and the output data register.

## Test plan
- Single-byte packet 0xA5 (last=1), `out_ready = 1` → output 0x51, 0x00, 0x01, 0xA5 on 4 consecutive cycles starting 1 cycle after acceptance; `in_ready` back to 1 the next cycle.
- 5-byte packet 01..05, `out_ready` toggling 1,0,1,0 → output 51,00,05,01,02,03,04,05 with `out_data` stable on every stalled cycle; no duplicates or drops.
- Packet of 2050 bytes (last on the 2050th) → first frame has length 0x0800 with bytes 0..2047; second frame has length 0x0002 with the remaining 2 bytes.
- `in_valid` held high during transmission → `in_ready = 0` and no bytes are written until the frame completes; the next packet is framed correctly.
- `clear` asserted during DATA of a 10-byte frame → `out_valid = 0` the next cycle; a subsequent 1-byte packet 0x7E yields 51,00,01,7E.
- Back-to-back packets 3 and 1 bytes, `out_ready = 1` → 51,00,03,x,y,z then 51,00,01,w; no header is lost and the lengths are correct.
